// File: rtl/vreg_group_seq.sv
// Vector register-group address sequencer: turns one instruction's register-group
// request into one architectural address per operand channel per beat.
module vreg_group_seq #(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_CH     = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [2:0]                   req_vlmul,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] req_base,
    input  logic [NUM_CH-1:0]            req_ch_en,
    input  logic [NUM_CH-1:0]            req_wide,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH*ADDR_WIDTH-1:0] out_addr,
    output logic [NUM_CH-1:0]            out_ch_en,
    output logic [2:0]                   out_beat,
    output logic                         out_last,
    output logic                         err,
    output logic [1:0]                   err_code
);

    localparam int AW = ADDR_WIDTH;
    localparam int BW = NUM_CH * ADDR_WIDTH;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    // Group size minus one, used both as the alignment mask and the last beat index.
    function automatic logic [3:0] grp_mask(input logic [2:0] vlmul, input logic wide);
        logic [3:0] m;
        case (vlmul)
            3'b000:  m = wide ? 4'd1  : 4'd0;
            3'b001:  m = wide ? 4'd3  : 4'd1;
            3'b010:  m = wide ? 4'd7  : 4'd3;
            3'b011:  m = wide ? 4'd15 : 4'd7;
            default: m = 4'd0;
        endcase
        return m;
    endfunction

    function automatic logic is_aligned(input logic [AW-1:0] base, input logic [3:0] mask);
        return (base & AW'(mask)) == '0;
    endfunction

    // Non-widened channels of a widened instruction advance every other beat.
    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] base,
                                                input logic [2:0]    beat,
                                                input logic          ch_wide,
                                                input logic          wflag);
        logic [2:0] off;
        off = (ch_wide || !wflag) ? beat : (beat >> 1);
        return base + AW'(off);
    endfunction

    function automatic logic [BW-1:0] group_addr(input logic [BW-1:0]     base,
                                                 input logic [NUM_CH-1:0] en,
                                                 input logic [NUM_CH-1:0] wide,
                                                 input logic              wflag,
                                                 input logic [2:0]        beat);
        logic [BW-1:0] a;
        a = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (en[k]) begin
                a[k*AW +: AW] = beat_addr(base[k*AW +: AW], beat, wide[k], wflag);
            end
        end
        return a;
    endfunction

    state_t              state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [BW-1:0]       out_addr_q, out_addr_d;
    logic [NUM_CH-1:0]   out_ch_en_q, out_ch_en_d;
    logic [2:0]          out_beat_q, out_beat_d;
    logic                out_last_q, out_last_d;
    logic                err_q, err_d;
    logic [1:0]          err_code_q, err_code_d;

    logic [BW-1:0]       base_q, base_d;
    logic [NUM_CH-1:0]   wide_q, wide_d;
    logic                wflag_q, wflag_d;
    logic [2:0]          last_q, last_d;

    logic                any_wide;
    logic                misaligned;
    logic                overflow;
    logic [1:0]          chk_code;
    logic [3:0]          req_last;
    logic [2:0]          next_beat;

    assign req_ready = (state_q == IDLE) && !rst;
    assign any_wide  = |(req_ch_en & req_wide);
    assign req_last  = grp_mask(req_vlmul, any_wide);
    assign next_beat = out_beat_q + 3'd1;

    always_comb begin
        misaligned = 1'b0;
        overflow   = 1'b0;
        chk_code   = 2'b00;
        for (int k = 0; k < NUM_CH; k++) begin
            if (req_ch_en[k]) begin
                if (!is_aligned(req_base[k*AW +: AW], grp_mask(req_vlmul, req_wide[k]))) begin
                    misaligned = 1'b1;
                end
                if (req_wide[k] && (req_vlmul == 3'b011)) begin
                    overflow = 1'b1;
                end
            end
        end
        if (req_vlmul == 3'b100) begin
            chk_code = 2'b01;
        end else if (misaligned) begin
            chk_code = 2'b10;
        end else if (overflow) begin
            chk_code = 2'b11;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_ch_en_d = out_ch_en_q;
        out_beat_d  = out_beat_q;
        out_last_d  = out_last_q;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        base_d      = base_q;
        wide_d      = wide_q;
        wflag_d     = wflag_q;
        last_d      = last_q;

        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (chk_code != 2'b00) begin
                            err_d      = 1'b1;
                            err_code_d = chk_code;
                        end else begin
                            state_d     = BUSY;
                            base_d      = req_base;
                            wide_d      = req_wide;
                            wflag_d     = any_wide;
                            last_d      = req_last[2:0];
                            out_valid_d = 1'b1;
                            out_ch_en_d = req_ch_en;
                            out_beat_d  = 3'd0;
                            out_last_d  = (req_last[2:0] == 3'd0);
                            out_addr_d  = group_addr(req_base, req_ch_en, req_wide, any_wide, 3'd0);
                        end
                    end
                end
                BUSY: begin
                    if (out_ready) begin
                        if (out_last_q) begin
                            state_d     = IDLE;
                            out_valid_d = 1'b0;
                        end else begin
                            out_beat_d = next_beat;
                            out_last_d = (next_beat == last_q);
                            out_addr_d = group_addr(base_q, out_ch_en_q, wide_q, wflag_q, next_beat);
                        end
                    end
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_ch_en_q <= '0;
            out_beat_q  <= 3'd0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_ch_en_q <= out_ch_en_d;
            out_beat_q  <= out_beat_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    // Sequence context is only read while BUSY, so it carries no reset.
    always_ff @(posedge clk) begin
        base_q  <= base_d;
        wide_q  <= wide_d;
        wflag_q <= wflag_d;
        last_q  <= last_d;
    end

    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_ch_en = out_ch_en_q;
    assign out_beat  = out_beat_q;
    assign out_last  = out_last_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_vreg_group_seq.sv
// Scoreboard bench for vreg_group_seq: directed plus randomized requests checked
// against a plain-arithmetic model of the register-group rules.
module tb_vreg_group_seq;

    localparam int AW = 5;
    localparam int NC = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            flush = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [2:0]      req_vlmul = 3'd0;
    logic [NC*AW-1:0] req_base = '0;
    logic [NC-1:0]   req_ch_en = '0;
    logic [NC-1:0]   req_wide = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [NC*AW-1:0] out_addr;
    logic [NC-1:0]   out_ch_en;
    logic [2:0]      out_beat;
    logic            out_last;
    logic            err;
    logic [1:0]      err_code;

    vreg_group_seq #(.ADDR_WIDTH(AW), .NUM_CH(NC)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_vlmul(req_vlmul),
        .req_base(req_base), .req_ch_en(req_ch_en), .req_wide(req_wide),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_ch_en(out_ch_en), .out_beat(out_beat), .out_last(out_last),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NC*AW-1:0] addr;
        logic [NC-1:0]    en;
        logic [2:0]       beat;
        logic             last;
    } beat_t;

    beat_t      exp_q[$];
    logic [1:0] err_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: group rules evaluated directly with integer arithmetic.
    function automatic void model(input logic [2:0] vlmul, input logic [NC*AW-1:0] base,
                                  input logic [NC-1:0] en, input logic [NC-1:0] wide);
        int g, gw, n, code, bk, sz;
        bit wflag;
        beat_t e;
        g     = (vlmul < 4) ? (1 << vlmul) : 1;
        gw    = (vlmul < 4) ? 2 * g : 1;
        wflag = |(en & wide);
        code  = 0;
        if (vlmul == 3'b100) code = 1;
        else begin
            for (int k = 0; k < NC; k++) begin
                bk = int'(base[k*AW +: AW]);
                sz = wide[k] ? gw : g;
                if (en[k] && (bk % sz) != 0) code = 2;
            end
            if (code == 0)
                for (int k = 0; k < NC; k++)
                    if (en[k] && wide[k] && vlmul == 3'b011) code = 3;
        end
        if (code != 0) begin
            err_q.push_back(2'(code));
            return;
        end
        n = wflag ? gw : g;
        for (int b = 0; b < n; b++) begin
            e = '0;
            for (int k = 0; k < NC; k++) begin
                bk = int'(base[k*AW +: AW]);
                if (en[k]) e.addr[k*AW +: AW] = AW'(bk + ((wide[k] || !wflag) ? b : b / 2));
            end
            e.en   = en;
            e.beat = 3'(b);
            e.last = (b == n - 1);
            exp_q.push_back(e);
        end
    endfunction

    task automatic send(input logic [2:0] vlmul, input logic [NC*AW-1:0] base,
                        input logic [NC-1:0] en, input logic [NC-1:0] wide, input bit fl);
        int t = 0;
        @(posedge clk); #1;
        while (!req_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!req_ready) begin
            check("req_ready_wait", 32'(req_ready), 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_vlmul = vlmul;
        req_base  = base;
        req_ch_en = en;
        req_wide  = wide;
        flush     = fl;
        @(posedge clk);
        if (!fl) model(vlmul, base, en, wide);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic wait_beat(input logic [2:0] b, output bit ok);
        int t = 0;
        ok = 1'b0;
        while (t < 200) begin
            @(posedge clk); #1;
            if (out_valid && out_beat == b) begin
                ok = 1'b1;
                return;
            end
            t++;
        end
        check("wait_beat_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(req_ready && exp_q.size() == 0 && err_q.size() == 0) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_timeout", 32'(t < 300), 32'd1);
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops expectations whenever the DUT presents a consumed beat or an error.
    bit               prev_stall = 1'b0;
    logic [NC*AW-1:0] prev_addr;
    logic [2:0]       prev_beat;
    logic             prev_last;
    logic [NC-1:0]    prev_en;
    beat_t            got;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_addr", 32'(out_addr), 32'(prev_addr));
                check("stall_beat", 32'(out_beat), 32'(prev_beat));
                check("stall_last", 32'(out_last), 32'(prev_last));
                check("stall_en", 32'(out_ch_en), 32'(prev_en));
            end
            if (out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got beat %0d addr %0h, required no beat", out_beat, out_addr);
                end else begin
                    got = exp_q.pop_front();
                    check("addr", 32'(out_addr), 32'(got.addr));
                    check("ch_en", 32'(out_ch_en), 32'(got.en));
                    check("beat", 32'(out_beat), 32'(got.beat));
                    check("last", 32'(out_last), 32'(got.last));
                end
            end
            if (err) begin
                if (err_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_err: got code %0d, required no err", err_code);
                end else begin
                    check("err_code", 32'(err_code), 32'(err_q.pop_front()));
                end
            end
            prev_stall = out_valid && !out_ready && !flush;
            prev_addr  = out_addr;
            prev_beat  = out_beat;
            prev_last  = out_last;
            prev_en    = out_ch_en;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    function automatic logic [NC*AW-1:0] bases(input int b0, input int b1, input int b2);
        return {AW'(b2), AW'(b1), AW'(b0)};
    endfunction

    initial begin
        logic [2:0]       vl;
        logic [NC*AW-1:0] bs;
        logic [NC-1:0]    en, wd;
        bit               ok;
        int               pattern[6] = '{1, 0, 0, 1, 1, 1};

        #1 rst = 1'b1;
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_out_meta", {out_ch_en, out_beat, out_last, err, err_code}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        #1 check("post_rst_ready", 32'(req_ready), 32'd1);

        // Four-beat group, ready stays high; check the one-cycle bubble.
        out_ready = 1'b1;
        send(3'b010, bases(8, 4, 12), 3'b111, 3'b000, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        check("ready_during_last", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("ready_after_last", 32'(req_ready), 32'd1);
        wait_idle();

        send(3'b000, bases(3, 5, 6), 3'b111, 3'b100, 1'b0);
        wait_idle();
        send(3'b011, bases(0, 8, 16), 3'b111, 3'b100, 1'b0);
        send(3'b100, bases(0, 0, 0), 3'b111, 3'b000, 1'b0);
        send(3'b001, bases(3, 0, 0), 3'b001, 3'b000, 1'b0);
        send(3'b110, bases(7, 0, 0), 3'b001, 3'b000, 1'b0);
        send(3'b000, bases(9, 9, 9), 3'b000, 3'b000, 1'b0);
        wait_idle();

        // Backpressure pattern during a four-beat sequence.
        send(3'b010, bases(16, 20, 24), 3'b111, 3'b000, 1'b0);
        foreach (pattern[i]) begin
            out_ready = pattern[i][0];
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_idle();

        // Flush on beat 1 of 8, then a normal request.
        send(3'b011, bases(8, 16, 24), 3'b111, 3'b000, 1'b0);
        wait_beat(3'd1, ok);
        if (ok) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            exp_q.delete();
            check("flush_drops_valid", 32'(out_valid), 32'd0);
        end
        send(3'b001, bases(2, 4, 6), 3'b111, 3'b000, 1'b0);
        wait_idle();

        // Flush coincident with an acceptance: no beats, no err.
        send(3'b100, bases(0, 0, 0), 3'b111, 3'b000, 1'b1);
        send(3'b001, bases(10, 12, 14), 3'b111, 3'b000, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        check("flush_accept_idle", 32'(req_ready), 32'd1);

        // Reset in the middle of a sequence.
        send(3'b011, bases(0, 8, 16), 3'b111, 3'b000, 1'b0);
        wait_beat(3'd2, ok);
        if (ok) begin
            rst = 1'b1;
            #1;
            check("midrst_valid", 32'(out_valid), 32'd0);
            check("midrst_addr", 32'(out_addr), 32'd0);
            check("midrst_meta", {out_ch_en, out_beat, out_last, err, err_code}, 32'd0);
            check("midrst_ready", 32'(req_ready), 32'd0);
            exp_q.delete();
            @(posedge clk); #1 rst = 1'b0;
            #1 check("midrst_ready_after", 32'(req_ready), 32'd1);
        end
        send(3'b001, bases(4, 6, 8), 3'b011, 3'b010, 1'b0);
        wait_idle();

        // Randomized traffic with random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            vl = 3'($urandom_range(0, 7));
            en = 3'($urandom_range(0, 7));
            if (vl == 3'b100 && en == 3'b000) en = 3'b001;
            wd = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            for (int k = 0; k < NC; k++) begin
                bs[k*AW +: AW] = AW'($urandom_range(0, 31));
                if ($urandom_range(0, 3) != 0)
                    bs[k*AW +: AW] = bs[k*AW +: AW] & ~AW'(15 >> $urandom_range(0, 4));
            end
            send(vl, bs, en, wd, ($urandom_range(0, 19) == 0));
        end
        wait_idle();
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (4) @(posedge clk);

        check("exp_left", 32'(exp_q.size()), 32'd0);
        check("err_left", 32'(err_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vreg_group_seq.md
# vreg_group_seq

Multi-channel vector register-group address sequencer: accepts one instruction's register-group request (up to NUM_CH operand channels) and emits one architectural register address per channel per beat. Supports the full RVV vlmul encoding (integer and fractional), per-channel widening (EMUL = 2·LMUL), alignment and legality checking, downstream backpressure and flush. It sits between decode and the vector register file read/write ports, replacing the single-channel, no-backpressure group address generator.

## Interface
- ADDR_WIDTH, 5: register address width; must be ≥ 3.
- NUM_CH, 3: operand channels, e.g. ch0 = vs1, ch1 = vs2, ch2 = vd.
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset. Asynchronous, active-high.
- flush  input  1  synchronous abort of any in-flight sequence.
- req_valid  input  1  request present.
- req_ready  output  1  high in IDLE while rst low; low otherwise.
- req_vlmul  input  3  RVV vlmul encoding.
- req_base  input  NUM_CH*ADDR_WIDTH  base register per channel; ch k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- req_ch_en  input  NUM_CH  channel used by the instruction.
- req_wide  input  NUM_CH  channel uses EMUL = 2·LMUL.
- out_valid  output  1  beat valid.
- out_ready  input  1  beat consumed.
- out_addr  output  NUM_CH*ADDR_WIDTH  per-channel register address for this beat; 0 for disabled channels.
- out_ch_en  output  NUM_CH  registered copy of req_ch_en.
- out_beat  output  3  beat index, 0-based.
- out_last  output  1  final beat of sequence.
- err  output  1  one-cycle pulse: request rejected.
- err_code  output  2  01 reserved vlmul, 10 misaligned base, 11 widen overflow; holds its value until the next err.

## Operation
- States: IDLE, BUSY.
- A request is accepted when req_valid & req_ready.
- Group size G:
  - vlmul 000/001/010/011 gives G = 1/2/4/8.
  - vlmul 101/110/111 (fractional) gives G = 1.
  - vlmul 100 is reserved.
- Widened group size: Gw = 2G for integer LMUL; Gw = 1 for fractional LMUL.
- Legality checks, evaluated over enabled channels only, first match wins:
  - vlmul = 100 gives code 01.
  - base not a multiple of its channel's group size (Gw if the channel is widened, else G) gives code 10.
  - a widened channel with vlmul = 011 gives code 11.
- Illegal request: stay in IDLE, emit no beats, pulse err the cycle after acceptance with err_code set.
- Legal request: latch the bases, ch_en, N and the widened flag, then go to BUSY.
  - N = Gw if any enabled channel is widened (widened flag set); otherwise N = G.
  - N = 1 with all channels disabled is still legal; one beat is emitted.
- Beat b (0..N-1), per enabled channel:
  - widened channel, or widened flag clear: addr = base + b.
  - non-widened channel with widened flag set: addr = base + (b >> 1).
  - All sums are ADDR_WIDTH wide. Alignment plus ADDR_WIDTH ≥ 3 guarantee no wrap.
- Advance b only on out_valid & out_ready.
- After the out_last beat is consumed, return to IDLE.
- flush: go to IDLE next cycle and drop out_valid. flush has priority over everything except rst.
- Reset mid-sequence: immediate return to IDLE with all outputs at their reset values.

## Timing
- Reset values: state IDLE; out_valid 0, out_addr 0, out_ch_en 0, out_beat 0, out_last 0, err 0, err_code 00. req_ready 0 while rst is high.
- Acceptance at edge T: out_valid high from T+1 with beat 0. req_ready low from T+1.
- While out_valid & !out_ready, every out_* signal holds stable.
- With out_ready held high, a legal N-beat request occupies N consecutive cycles.
- Last beat consumed at edge E: req_ready high from E+1. This gives one bubble between sequences; no back-to-back acceptance.
- err pulses exactly one cycle, at T+1. req_ready stays high, so the next request can be accepted at T+1.
- flush together with an accepting handshake: the request is dropped, no err is raised, and the unit is in IDLE at T+1.
- out_last = (out_beat == N-1), registered alongside out_beat.

## Test plan
- vlmul=010, base ch0=8 ch1=4 ch2=12, all enabled, out_ready=1: 4 beats; ch0 8,9,10,11; ch1 4..7; ch2 12..15; out_last only on beat 3; req_ready high 1 cycle later.
- vlmul=000, req_wide=100 (ch2 widened), bases 3/5/6: 2 beats; ch0 3,3; ch1 5,5; ch2 6,7.
- vlmul=011 with a widened channel: err=1 with code 11, no out_valid. vlmul=100: code 01. vlmul=001 with base 3: code 10. vlmul=110, ch0 base 7: legal, 1 beat, addr 7.
- Backpressure: out_ready toggled 1,0,0,1 during a 4-beat sequence: beat index and addresses held while stalled; 4 beats total, none skipped or duplicated.
- flush asserted on beat 1 of 8: out_valid low the next cycle; next request accepted normally starting at beat 0.
- rst asserted mid-sequence: all outputs 0 immediately; after release, req_ready=1 and a fresh request runs correctly.
